// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_LS = 2'd2
  } arb_state_e;

  // Winner chosen by the pick logic in an IDLE cycle.
  typedef enum logic [1:0] {
    PICK_NONE = 2'd0,
    PICK_IF   = 2'd1,
    PICK_LS   = 2'd2
  } pick_e;

  localparam int STREAK_W          = 4;
  localparam int DEF_MAX_LS_STREAK = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: LS first, IF once LS has hogged the bus
// for the allowed streak, and never a fetch that is being flushed.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  if_req,
  input  logic  ls_req,
  input  logic  flush_if,
  input  logic  at_limit,
  output pick_e pick
);

  logic if_ok;
  assign if_ok = if_req & ~flush_if;

  // LS wins unless a live fetch is starving; a flushed fetch can't win.
  always_comb begin
    pick = PICK_NONE;
    if (ls_req && !(if_ok && at_limit)) pick = PICK_LS;
    else if (if_ok)                     pick = PICK_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory bus between fetch and load/store, one registered
// transaction at a time, with a starvation bound on consecutive LS grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            flush_if,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_ack,
  output logic            bus_req,
  output logic            bus_we,
  output logic [DW/8-1:0] bus_be,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack,
  output logic            stall_if,
  output logic            stall_mem
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic                drop;
  logic                at_limit;
  pick_e               pick;

  assign at_limit = (streak == STREAK_MAX);

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .ls_req   (ls_req),
    .flush_if (flush_if),
    .at_limit (at_limit),
    .pick     (pick)
  );

  // Acks are same-cycle with bus_ack; a fetch flushed now or earlier is masked.
  assign if_ack    = (state == ARB_GNT_IF) & bus_ack & ~drop & ~flush_if;
  assign ls_ack    = (state == ARB_GNT_LS) & bus_ack;
  assign if_rdata  = bus_rdata;
  assign ls_rdata  = bus_rdata;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = ls_req & ~ls_ack;

  // Grant FSM, bus registers, LS streak counter and fetch-drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      streak    <= '0;
      drop      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          case (pick)
            PICK_LS: begin
              state     <= ARB_GNT_LS;
              bus_req   <= 1'b1;
              bus_we    <= ls_we;
              bus_be    <= ls_be;
              bus_addr  <= ls_addr;
              bus_wdata <= ls_wdata;
              // Streak only counts while a fetch is actually waiting.
              if (!if_req)           streak <= '0;
              else if (!at_limit)    streak <= streak + STREAK_W'(1);
            end
            PICK_IF: begin
              state     <= ARB_GNT_IF;
              bus_req   <= 1'b1;
              bus_we    <= 1'b0;
              bus_be    <= '1;
              bus_addr  <= if_addr;
              bus_wdata <= '0;
              streak    <= '0;
            end
            default: ;
          endcase
        end
        ARB_GNT_IF: begin
          if (bus_ack) begin
            state   <= ARB_IDLE;
            bus_req <= 1'b0;
            drop    <= 1'b0;
          end else if (flush_if) begin
            drop    <= 1'b1;
          end
        end
        ARB_GNT_LS: begin
          if (bus_ack) begin
            state   <= ARB_IDLE;
            bus_req <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, all checked every cycle against
// a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, flush_if, ls_req, ls_we, bus_ack;
  logic [AW-1:0] if_addr, ls_addr;
  logic [3:0]    ls_be;
  logic [DW-1:0] ls_wdata, bus_rdata;
  logic [DW-1:0] if_rdata, ls_rdata, bus_wdata;
  logic          if_ack, ls_ack, bus_req, bus_we, stall_if, stall_mem;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: one bus transaction in flight or none.
  bit            m_busy, m_is_if, m_we, m_drop;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_streak;
  bit            e_if_ack, e_ls_ack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    m_busy = 0; m_is_if = 0; m_we = 0; m_drop = 0;
    m_be = '0; m_addr = '0; m_wdata = '0; m_streak = 0;
  endfunction

  function automatic void mdl_step();
    bit if_live;
    if (!m_busy) begin
      if_live = if_req && !flush_if;
      if (ls_req && !(if_live && m_streak >= MAXS)) begin
        m_busy = 1; m_is_if = 0; m_we = ls_we; m_be = ls_be;
        m_addr = ls_addr; m_wdata = ls_wdata;
        m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else if (if_live) begin
        m_busy = 1; m_is_if = 1; m_we = 0; m_be = 4'hF;
        m_addr = if_addr; m_wdata = '0; m_streak = 0;
      end
    end else if (bus_ack) begin
      m_busy = 0; m_drop = 0;
    end else if (m_is_if && flush_if) begin
      m_drop = 1;
    end
  endfunction

  // One cycle: inputs were set at the falling edge; check, advance model.
  task automatic tick();
    #1;
    if (rst) mdl_reset();
    e_if_ack = m_busy && m_is_if && bus_ack && !m_drop && !flush_if;
    e_ls_ack = m_busy && !m_is_if && bus_ack;
    chk("bus_req",   bus_req,   m_busy);
    chk("bus_we",    bus_we,    m_we);
    chk("bus_be",    bus_be,    m_be);
    chk("bus_addr",  bus_addr,  m_addr);
    chk("bus_wdata", bus_wdata, m_wdata);
    chk("if_ack",    if_ack,    e_if_ack);
    chk("ls_ack",    ls_ack,    e_ls_ack);
    chk("stall_if",  stall_if,  if_req && !e_if_ack);
    chk("stall_mem", stall_mem, ls_req && !e_ls_ack);
    if (e_if_ack) chk("if_rdata", if_rdata, bus_rdata);
    if (e_ls_ack) chk("ls_rdata", ls_rdata, bus_rdata);
    if (!rst) mdl_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; flush_if = 0; ls_req = 0; ls_we = 0; bus_ack = 0;
    if_addr = '0; ls_addr = '0; ls_be = '0; ls_wdata = '0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    rst = 0;
  endtask

  int  cnt;
  bit  if_pend, ls_pend;

  initial begin
    mdl_reset();
    rst = 1; idle_inputs();
    @(negedge clk);
    tick();
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, '0);
    rst = 0;
    tick();

    // Lone fetch with zero-wait bus.
    if_req = 1; if_addr = 32'h100;
    tick();
    bus_ack = 1; bus_rdata = 32'h0000_0013;
    #1;
    chk("fetch_bus_req", bus_req, 1'b1);
    chk("fetch_addr", bus_addr, 32'h100);
    chk("fetch_ack", if_ack, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h0000_0013);
    chk("fetch_stall", stall_if, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Simultaneous requests: LS first, IF after one idle cycle.
    if_req = 1; if_addr = 32'h104; ls_req = 1; ls_addr = 32'h2000; ls_be = 4'hF;
    tick();
    bus_ack = 1;
    #1;
    chk("sim_ls_addr", bus_addr, 32'h2000);
    chk("sim_ls_ack", ls_ack, 1'b1);
    chk("sim_stall_if", stall_if, 1'b1);
    tick();
    ls_req = 0; bus_ack = 0;
    #1 chk("sim_turn_bus_req", bus_req, 1'b0);
    tick();
    bus_ack = 1;
    #1;
    chk("sim_if_addr", bus_addr, 32'h104);
    chk("sim_if_ack", if_ack, 1'b1);
    tick();
    idle_inputs();
    tick();

    // Store with three wait cycles.
    ls_req = 1; ls_we = 1; ls_be = 4'h3; ls_addr = 32'h3000; ls_wdata = 32'hDEAD_BEEF;
    tick();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i == 3);
      #1;
      chk("st_we", bus_we, 1'b1);
      chk("st_be", bus_be, 4'h3);
      chk("st_wdata", bus_wdata, 32'hDEAD_BEEF);
      if (ls_ack) cnt++;
      tick();
    end
    chk("st_ack_count", cnt, 1);
    idle_inputs();
    tick();

    // Starvation bound: continuous LS with IF waiting.
    if_req = 1; if_addr = 32'h400; ls_req = 1; ls_addr = 32'h5000; ls_be = 4'hF;
    bus_ack = 1; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (if_ack) break;
      if (ls_ack) cnt++;
      tick();
    end
    chk("starve_if_ack", if_ack, 1'b1);
    chk("starve_ls_grants", cnt, MAXS);
    tick();
    idle_inputs();
    tick();

    // Flush mid-fetch, then a new fetch.
    if_req = 1; if_addr = 32'h180;
    tick();
    flush_if = 1; if_addr = 32'h200;
    tick();
    flush_if = 0; bus_ack = 1;
    #1 chk("flush_masked", if_ack, 1'b0);
    tick();
    bus_ack = 0;
    #1 chk("flush_idle", bus_req, 1'b0);
    tick();
    bus_ack = 1;
    #1;
    chk("refetch_addr", bus_addr, 32'h200);
    chk("refetch_ack", if_ack, 1'b1);
    tick();
    idle_inputs();
    tick();

    // Reset during an LS grant, then a stray bus_ack.
    ls_req = 1; ls_addr = 32'h6000; ls_be = 4'hF;
    tick();
    tick();
    rst = 1;
    #1 chk("rst_mid_bus_req", bus_req, 1'b0);
    tick();
    rst = 0; ls_req = 0; bus_ack = 1;
    #1 chk("stray_ack", ls_ack, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Randomized traffic, requesters obeying the hold-until-ack protocol.
    if_pend = 0; ls_pend = 0;
    for (int c = 0; c < 4000; c++) begin
      if (if_pend && e_if_ack) if_pend = 0;
      if (ls_pend && e_ls_ack) ls_pend = 0;
      flush_if = ($urandom_range(15) == 0);
      if (if_pend && flush_if) if_addr = $urandom & 32'hFFFF_FFFC;
      if (!if_pend && $urandom_range(2) == 0) begin
        if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_pend && $urandom_range(1) == 0) begin
        ls_pend = 1; ls_we = $urandom_range(1); ls_be = $urandom_range(15);
        ls_addr = $urandom; ls_wdata = $urandom;
      end
      if_req = if_pend; ls_req = ls_pend;
      bus_ack = ($urandom_range(2) == 0);
      bus_rdata = $urandom;
      rst = ($urandom_range(499) == 0);
      if (rst) begin if_pend = 0; ls_pend = 0; if_req = 0; ls_req = 0; end
      tick();
      rst = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
